// File: rtl/a14_mem_timing_addr_pkg.sv
// a14_mem_timing_addr_pkg
//   Shared definitions for the A14 memory timing and addressing model:
//   - tpulse_t   : the T01..T11 and T12A pulses packed as bits [12:1]
//   - t_window() : OR of the timing pulses over an inclusive T range
//   - a14_regs_t : every registered output, held in its active-high form
//   - REGS_RESET : reset image of a14_regs_t. Each `_` port is the
//                  inverse of a field, so all-zero fields give 1 on `_` ports.
package a14_mem_timing_addr_pkg;

    localparam int T_LAST = 12;  // index 12 carries T12A

    typedef logic [T_LAST:1] tpulse_t;

    // True when any timing pulse from T<lo> to T<hi> is present.
    function automatic logic t_window(input tpulse_t t, input int lo, input int hi);
        logic hit;
        hit = 1'b0;
        for (int i = 1; i <= T_LAST; i++) begin
            if (i >= lo && i <= hi) begin
                hit = hit | t[i];
            end
        end
        return hit;
    endfunction

    typedef struct packed {
        logic [7:0] xb;
        logic [7:0] xt;
        logic [3:0] yb;
        logic [7:0] xbe;
        logic [7:0] xte;
        logic [3:0] ybe;
        logic       eras, rex, rey, wex, wey, zid, ihenv, setek;
        logic       sbe, sbeset, stbe, sbf, sbfset, stbf, strgat;
        logic       setab, setcd;
        logic [3:0] rope_reset;  // bit 0 = RESETA ... bit 3 = RESETD
        logic       clrope;
        logic       rop;         // ROP_ is low while this is set
        logic       tpge, tpgf, notest, ilp, rilp1;
        logic       br12b, wl11, wl16, r1c, rb1, rscg, wscg, rstk, redrst;
        logic       nsby;        // holds !SBY, so SBYREL_ follows SBY
        logic       whompa;
    } a14_regs_t;

    localparam a14_regs_t REGS_RESET = '0;

endpackage

// File: rtl/a14_decode.sv
// a14_decode
//   Combinational S register decode for the erasable core.
//   s[9:1]  : S09..S01
//   s11,s12 : bank bits S11, S12
//   scad    : special/central address, gojam : restart
//   xb, xt  : one-hot of S03..S01 and S06..S04
//   yb      : one-hot of S08..S07
//   eras    : this address is an erasable-memory cycle
module a14_decode
    import a14_mem_timing_addr_pkg::*;
(
    input  logic [9:1] s,
    input  logic       s11,
    input  logic       s12,
    input  logic       scad,
    input  logic       gojam,
    output logic [7:0] xb,
    output logic [7:0] xt,
    output logic [3:0] yb,
    output logic       eras
);

    always_comb begin
        xb = '0;
        xt = '0;
        yb = '0;
        xb[s[3:1]] = 1'b1;
        xt[s[6:4]] = 1'b1;
        yb[s[8:7]] = 1'b1;
    end

    // Addresses 0..7 are the central registers, not core.
    assign eras = ~s12 & ~s11 & (|s[9:4]) & ~scad & ~gojam;

endmodule

// File: rtl/a14_mem_timing_addr.sv
// a14_mem_timing_addr
//   AGC module A14: erasable X/Y selection, erasable read/write sequencing,
//   sense strobes, rope set/reset pulses, parity-test control and buffers.
//   Inputs : CLOCK, rst (async, active-high), S register bits, T01..T11/T12A
//            timing pulses, phases, rope clear requests, restart, standby,
//            control pulses, data bits and instruction context.
//   Outputs: address decodes and their enabled drivers, erasable and rope
//            drive, sense strobes, parity outputs and buffered signals.
//   Every output comes from a flop on CLOCK rising, one cycle after inputs.
module a14_mem_timing_addr
    import a14_mem_timing_addr_pkg::*;
(
    input  logic CLOCK, rst,
    input  logic S01, S02, S03, S04, S05, S06, S07, S08, S09,
    input  logic S01_, S02_, S03_, S04_, S05_, S06_, S07_, S08_, S09_,
    input  logic S11, S12,
    input  logic T01, T02, T03, T04, T05, T06, T07, T08, T09, T10, T11, T12A,
    input  logic T01_, T02_, T03_, T04_, T05_, T06_, T07_, T08_, T09_, T10_, T11_, T12_,
    input  logic PHS2_, PHS3_, PHS4_,
    input  logic CLEARA, CLEARB, CLEARC, CLEARD,
    input  logic GOJAM, GOJ1, SBY, SCAD, SCAD_,
    input  logic RSC_, WSC_, RT_, R1C_, RB1_, WHOMP_, NISQL_,
    input  logic BR12B, WL11, WL16,
    input  logic CHINC, PSEUDO, INOUT, DV3764, MP1, MAMU, TCSAJ3, TIMR, CGA14,
    input  logic MYCLMP, MNHSBF,
    output logic XB0, XB1, XB2, XB3, XB4, XB5, XB6, XB7,
    output logic XB0_, XB1_, XB2_, XB3_, XB4_, XB5_, XB6_, XB7_,
    output logic XT0, XT1, XT2, XT3, XT4, XT5, XT6, XT7,
    output logic XT0_, XT1_, XT2_, XT3_, XT4_, XT5_, XT6_, XT7_,
    output logic YB0, YB1, YB2, YB3, YB0_, YB1_, YB2_, YB3_,
    output logic XB0E, XB1E, XB2E, XB3E, XB4E, XB5E, XB6E, XB7E,
    output logic XT0E, XT1E, XT2E, XT3E, XT4E, XT5E, XT6E, XT7E,
    output logic YB0E, YB1E, YB2E, YB3E,
    output logic ERAS, ERAS_, FNERAS_,
    output logic REX, REY, WEX, WEY, ZID, IHENV, SETEK,
    output logic SBE, SBESET, STBE, SBF, SBFSET, STBF, STRGAT,
    output logic SETAB, SETAB_, SETCD, SETCD_, RESETA, RESETB, RESETC, RESETD,
    output logic CLROPE, ROP_,
    output logic TPARG_, TPGE, TPGF, NOTEST, NOTEST_, ILP, ILP_, RILP1, RILP1_,
    output logic BR12B_, WL11_, WL16_, R1C, RB1, RSCG_, WSCG_, CXB1_, RSTK_,
    output logic REDRST, SBYREL_, WHOMPA
);

    // The model works from the true address rails; complement rails, the
    // unused phases and context bits are gathered here to keep them visible.
    logic unused_inputs;
    assign unused_inputs = ^{S01_, S02_, S03_, S04_, S05_, S06_, S07_, S08_, S09_,
                             T01_, T02_, T03_, T04_, T05_, T06_, T07_, T08_, T09_,
                             T10_, T11_, T12_, PHS2_, PHS3_, SCAD_, NISQL_,
                             MAMU, TCSAJ3, CGA14};

    tpulse_t    t;
    logic [7:0] xb, xt;
    logic [3:0] yb;
    logic       eras, fixed, clamp, en_win;
    a14_regs_t  r, nxt;

    assign t = {T12A, T11, T10, T09, T08, T07, T06, T05, T04, T03, T02, T01};

    a14_decode u_decode (
        .s     ({S09, S08, S07, S06, S05, S04, S03, S02, S01}),
        .s11   (S11),
        .s12   (S12),
        .scad  (SCAD),
        .gojam (GOJAM),
        .xb    (xb),
        .xt    (xt),
        .yb    (yb),
        .eras  (eras)
    );

    assign fixed  = ~eras & ~SCAD;
    assign clamp  = MYCLMP | SBY;  // monitor clamp or standby kills core drive
    assign en_win = eras & t_window(t, 1, 9) & ~clamp;

    always_comb begin
        nxt            = REGS_RESET;
        nxt.xb         = xb;
        nxt.xt         = xt;
        nxt.yb         = yb;
        nxt.xbe        = en_win ? xb : '0;
        nxt.xte        = en_win ? xt : '0;
        nxt.ybe        = en_win ? yb : '0;
        nxt.eras       = eras;
        // Erasable cycle: read T02-T04, strobe T04, set EK T06, write T07-T09.
        nxt.rex        = eras & t_window(t, 2, 4) & ~clamp;
        nxt.rey        = eras & t_window(t, 2, 4) & ~clamp;
        nxt.sbeset     = eras & t[4];
        nxt.sbe        = eras & t[4] & ~PHS4_;
        nxt.stbe       = eras & t[4] & ~PHS4_;
        nxt.setek      = eras & t[6];
        nxt.ihenv      = eras & t_window(t, 7, 9);
        nxt.wex        = eras & t_window(t, 7, 9) & ~clamp;
        nxt.wey        = eras & t_window(t, 7, 9) & ~clamp;
        nxt.zid        = eras & t_window(t, 7, 9) & ~clamp;
        // Fixed (rope) cycle: S11 picks the A/B or C/D strand set.
        nxt.setab      = fixed & ~S11 & t_window(t, 1, 3);
        nxt.setcd      = fixed & S11 & t_window(t, 1, 3);
        nxt.sbfset     = fixed & t[4];
        nxt.sbf        = fixed & t[4] & ~PHS4_ & ~MNHSBF;
        nxt.stbf       = fixed & t[4] & ~PHS4_ & ~MNHSBF;
        nxt.rope_reset = (fixed & t_window(t, 6, 12)) ? {CLEARD, CLEARC, CLEARB, CLEARA} : 4'b0;
        nxt.rop        = fixed & t[8];
        nxt.clrope     = fixed & t[12];
        nxt.strgat     = nxt.stbe | nxt.stbf;
        nxt.notest     = CHINC | PSEUDO | INOUT | DV3764 | MP1 | SCAD;
        nxt.tpge       = t[7] & ~nxt.notest & eras;
        nxt.tpgf       = t[7] & ~nxt.notest & ~eras;
        // Clear takes priority over set so a restart always drops ILP.
        nxt.ilp        = (t[12] | GOJAM) ? 1'b0 : (nxt.strgat | r.ilp);
        nxt.rilp1      = r.ilp;
        nxt.br12b      = BR12B;
        nxt.wl11       = WL11;
        nxt.wl16       = WL16;
        nxt.r1c        = ~R1C_;
        nxt.rb1        = ~RB1_;
        nxt.rscg       = ~RSC_ & SCAD;
        nxt.wscg       = ~WSC_ & SCAD;
        nxt.rstk       = ~RT_ & TIMR;
        nxt.redrst     = GOJAM | GOJ1;
        nxt.nsby       = ~SBY;
        nxt.whompa     = ~WHOMP_ & ~SBY;
    end

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            r <= REGS_RESET;
        end else begin
            r <= nxt;
        end
    end

    assign {XB7, XB6, XB5, XB4, XB3, XB2, XB1, XB0}         = r.xb;
    assign {XB7_, XB6_, XB5_, XB4_, XB3_, XB2_, XB1_, XB0_} = ~r.xb;
    assign {XT7, XT6, XT5, XT4, XT3, XT2, XT1, XT0}         = r.xt;
    assign {XT7_, XT6_, XT5_, XT4_, XT3_, XT2_, XT1_, XT0_} = ~r.xt;
    assign {YB3, YB2, YB1, YB0}                             = r.yb;
    assign {YB3_, YB2_, YB1_, YB0_}                         = ~r.yb;
    assign {XB7E, XB6E, XB5E, XB4E, XB3E, XB2E, XB1E, XB0E} = r.xbe;
    assign {XT7E, XT6E, XT5E, XT4E, XT3E, XT2E, XT1E, XT0E} = r.xte;
    assign {YB3E, YB2E, YB1E, YB0E}                         = r.ybe;

    assign ERAS    = r.eras;
    assign ERAS_   = ~r.eras;
    assign FNERAS_ = ~r.eras;
    assign {REX, REY, WEX, WEY, ZID, IHENV, SETEK} = {r.rex, r.rey, r.wex, r.wey, r.zid, r.ihenv, r.setek};
    assign {SBE, SBESET, STBE, SBF, SBFSET, STBF, STRGAT} =
           {r.sbe, r.sbeset, r.stbe, r.sbf, r.sbfset, r.stbf, r.strgat};

    assign SETAB   = r.setab;
    assign SETAB_  = ~r.setab;
    assign SETCD   = r.setcd;
    assign SETCD_  = ~r.setcd;
    assign {RESETD, RESETC, RESETB, RESETA} = r.rope_reset;
    assign CLROPE  = r.clrope;
    assign ROP_    = ~r.rop;

    assign TPGE    = r.tpge;
    assign TPGF    = r.tpgf;
    assign TPARG_  = ~(r.tpge | r.tpgf);
    assign NOTEST  = r.notest;
    assign NOTEST_ = ~r.notest;
    assign ILP     = r.ilp;
    assign ILP_    = ~r.ilp;
    assign RILP1   = r.rilp1;
    assign RILP1_  = ~r.rilp1;

    assign BR12B_  = ~r.br12b;
    assign WL11_   = ~r.wl11;
    assign WL16_   = ~r.wl16;
    assign R1C     = r.r1c;
    assign RB1     = r.rb1;
    assign RSCG_   = ~r.rscg;
    assign WSCG_   = ~r.wscg;
    assign CXB1_   = ~r.xb[1];
    assign RSTK_   = ~r.rstk;
    assign REDRST  = r.redrst;
    assign SBYREL_ = ~r.nsby;
    assign WHOMPA  = r.whompa;

endmodule

// File: tb/tb_a14_mem_timing_addr.sv
module tb_a14_mem_timing_addr;

    // ---------------- clock / reset / stimulus signals ----------------
    logic CLOCK, rst;
    logic [9:1]  sv;
    logic [12:1] tv;   // [12] = T12A
    logic [3:0]  clr;  // [0] = CLEARA
    logic S11, S12, PHS2_, PHS3_, PHS4_, GOJAM, GOJ1, SBY, SCAD;
    logic RSC_, WSC_, RT_, R1C_, RB1_, WHOMP_, NISQL_, BR12B, WL11, WL16;
    logic CHINC, PSEUDO, INOUT, DV3764, MP1, MAMU, TCSAJ3, TIMR, CGA14, MYCLMP, MNHSBF;

    logic XB0, XB1, XB2, XB3, XB4, XB5, XB6, XB7, XB0_, XB1_, XB2_, XB3_, XB4_, XB5_, XB6_, XB7_;
    logic XT0, XT1, XT2, XT3, XT4, XT5, XT6, XT7, XT0_, XT1_, XT2_, XT3_, XT4_, XT5_, XT6_, XT7_;
    logic YB0, YB1, YB2, YB3, YB0_, YB1_, YB2_, YB3_;
    logic XB0E, XB1E, XB2E, XB3E, XB4E, XB5E, XB6E, XB7E, XT0E, XT1E, XT2E, XT3E, XT4E, XT5E, XT6E, XT7E;
    logic YB0E, YB1E, YB2E, YB3E, ERAS, ERAS_, FNERAS_, REX, REY, WEX, WEY, ZID, IHENV, SETEK;
    logic SBE, SBESET, STBE, SBF, SBFSET, STBF, STRGAT, SETAB, SETAB_, SETCD, SETCD_;
    logic RESETA, RESETB, RESETC, RESETD, CLROPE, ROP_;
    logic TPARG_, TPGE, TPGF, NOTEST, NOTEST_, ILP, ILP_, RILP1, RILP1_;
    logic BR12B_, WL11_, WL16_, R1C, RB1, RSCG_, WSCG_, CXB1_, RSTK_, REDRST, SBYREL_, WHOMPA;

    a14_mem_timing_addr dut (
        .CLOCK(CLOCK), .rst(rst),
        .S01(sv[1]), .S02(sv[2]), .S03(sv[3]), .S04(sv[4]), .S05(sv[5]), .S06(sv[6]),
        .S07(sv[7]), .S08(sv[8]), .S09(sv[9]),
        .S01_(~sv[1]), .S02_(~sv[2]), .S03_(~sv[3]), .S04_(~sv[4]), .S05_(~sv[5]),
        .S06_(~sv[6]), .S07_(~sv[7]), .S08_(~sv[8]), .S09_(~sv[9]),
        .S11(S11), .S12(S12),
        .T01(tv[1]), .T02(tv[2]), .T03(tv[3]), .T04(tv[4]), .T05(tv[5]), .T06(tv[6]),
        .T07(tv[7]), .T08(tv[8]), .T09(tv[9]), .T10(tv[10]), .T11(tv[11]), .T12A(tv[12]),
        .T01_(~tv[1]), .T02_(~tv[2]), .T03_(~tv[3]), .T04_(~tv[4]), .T05_(~tv[5]), .T06_(~tv[6]),
        .T07_(~tv[7]), .T08_(~tv[8]), .T09_(~tv[9]), .T10_(~tv[10]), .T11_(~tv[11]), .T12_(~tv[12]),
        .PHS2_(PHS2_), .PHS3_(PHS3_), .PHS4_(PHS4_),
        .CLEARA(clr[0]), .CLEARB(clr[1]), .CLEARC(clr[2]), .CLEARD(clr[3]),
        .GOJAM(GOJAM), .GOJ1(GOJ1), .SBY(SBY), .SCAD(SCAD), .SCAD_(~SCAD),
        .RSC_(RSC_), .WSC_(WSC_), .RT_(RT_), .R1C_(R1C_), .RB1_(RB1_), .WHOMP_(WHOMP_), .NISQL_(NISQL_),
        .BR12B(BR12B), .WL11(WL11), .WL16(WL16),
        .CHINC(CHINC), .PSEUDO(PSEUDO), .INOUT(INOUT), .DV3764(DV3764), .MP1(MP1), .MAMU(MAMU),
        .TCSAJ3(TCSAJ3), .TIMR(TIMR), .CGA14(CGA14), .MYCLMP(MYCLMP), .MNHSBF(MNHSBF),
        .XB0(XB0), .XB1(XB1), .XB2(XB2), .XB3(XB3), .XB4(XB4), .XB5(XB5), .XB6(XB6), .XB7(XB7),
        .XB0_(XB0_), .XB1_(XB1_), .XB2_(XB2_), .XB3_(XB3_), .XB4_(XB4_), .XB5_(XB5_), .XB6_(XB6_), .XB7_(XB7_),
        .XT0(XT0), .XT1(XT1), .XT2(XT2), .XT3(XT3), .XT4(XT4), .XT5(XT5), .XT6(XT6), .XT7(XT7),
        .XT0_(XT0_), .XT1_(XT1_), .XT2_(XT2_), .XT3_(XT3_), .XT4_(XT4_), .XT5_(XT5_), .XT6_(XT6_), .XT7_(XT7_),
        .YB0(YB0), .YB1(YB1), .YB2(YB2), .YB3(YB3), .YB0_(YB0_), .YB1_(YB1_), .YB2_(YB2_), .YB3_(YB3_),
        .XB0E(XB0E), .XB1E(XB1E), .XB2E(XB2E), .XB3E(XB3E), .XB4E(XB4E), .XB5E(XB5E), .XB6E(XB6E), .XB7E(XB7E),
        .XT0E(XT0E), .XT1E(XT1E), .XT2E(XT2E), .XT3E(XT3E), .XT4E(XT4E), .XT5E(XT5E), .XT6E(XT6E), .XT7E(XT7E),
        .YB0E(YB0E), .YB1E(YB1E), .YB2E(YB2E), .YB3E(YB3E),
        .ERAS(ERAS), .ERAS_(ERAS_), .FNERAS_(FNERAS_),
        .REX(REX), .REY(REY), .WEX(WEX), .WEY(WEY), .ZID(ZID), .IHENV(IHENV), .SETEK(SETEK),
        .SBE(SBE), .SBESET(SBESET), .STBE(STBE), .SBF(SBF), .SBFSET(SBFSET), .STBF(STBF), .STRGAT(STRGAT),
        .SETAB(SETAB), .SETAB_(SETAB_), .SETCD(SETCD), .SETCD_(SETCD_),
        .RESETA(RESETA), .RESETB(RESETB), .RESETC(RESETC), .RESETD(RESETD), .CLROPE(CLROPE), .ROP_(ROP_),
        .TPARG_(TPARG_), .TPGE(TPGE), .TPGF(TPGF), .NOTEST(NOTEST), .NOTEST_(NOTEST_),
        .ILP(ILP), .ILP_(ILP_), .RILP1(RILP1), .RILP1_(RILP1_),
        .BR12B_(BR12B_), .WL11_(WL11_), .WL16_(WL16_), .R1C(R1C), .RB1(RB1), .RSCG_(RSCG_), .WSCG_(WSCG_),
        .CXB1_(CXB1_), .RSTK_(RSTK_), .REDRST(REDRST), .SBYREL_(SBYREL_), .WHOMPA(WHOMPA)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] xb, xt;
        logic [3:0] yb;
        logic [7:0] xbe, xte;
        logic [3:0] ybe;
        logic eras, rex, rey, wex, wey, zid, ihenv, setek;
        logic sbe, sbeset, stbe, sbf, sbfset, stbf, strgat, setab, setcd;
        logic [3:0] rst4;
        logic clrope, rop, tpge, tpgf, notest, ilp, rilp1;
        logic br12b, wl11, wl16, r1c, rb1, rscg, wscg, rstk, redrst, nsby, whompa;
    } plain_t;

    localparam int W = 108;
    logic [W-1:0] exp_q[$];
    logic m_ilp;
    int total = 0;
    int bad = 0;

    function automatic logic tin(input int lo, input int hi);
        logic hit = 1'b0;
        for (int i = lo; i <= hi; i++) hit = hit | tv[i];
        return hit;
    endfunction

    // Output image in a fixed group layout; `_` ports are derived here.
    function automatic logic [W-1:0] assemble(input plain_t p);
        logic [19:0] dec, drv;
        logic [9:0]  erg, rope;
        logic [6:0]  sense;
        logic [8:0]  par;
        logic [11:0] bufg;
        dec   = {p.xb, p.xt, p.yb};
        drv   = {p.xbe, p.xte, p.ybe};
        erg   = {p.eras, ~p.eras, ~p.eras, p.rex, p.rey, p.wex, p.wey, p.zid, p.ihenv, p.setek};
        sense = {p.sbe, p.sbeset, p.stbe, p.sbf, p.sbfset, p.stbf, p.strgat};
        rope  = {p.setab, ~p.setab, p.setcd, ~p.setcd, p.rst4[0], p.rst4[1], p.rst4[2], p.rst4[3],
                 p.clrope, ~p.rop};
        par   = {~(p.tpge | p.tpgf), p.tpge, p.tpgf, p.notest, ~p.notest, p.ilp, ~p.ilp, p.rilp1, ~p.rilp1};
        bufg  = {~p.br12b, ~p.wl11, ~p.wl16, p.r1c, p.rb1, ~p.rscg, ~p.wscg, ~p.xb[1], ~p.rstk,
                 p.redrst, ~p.nsby, p.whompa};
        return {dec, ~dec, drv, erg, sense, rope, par, bufg};
    endfunction

    function automatic logic [W-1:0] observed();
        return {XB7, XB6, XB5, XB4, XB3, XB2, XB1, XB0, XT7, XT6, XT5, XT4, XT3, XT2, XT1, XT0,
                YB3, YB2, YB1, YB0,
                XB7_, XB6_, XB5_, XB4_, XB3_, XB2_, XB1_, XB0_, XT7_, XT6_, XT5_, XT4_, XT3_, XT2_, XT1_, XT0_,
                YB3_, YB2_, YB1_, YB0_,
                XB7E, XB6E, XB5E, XB4E, XB3E, XB2E, XB1E, XB0E, XT7E, XT6E, XT5E, XT4E, XT3E, XT2E, XT1E, XT0E,
                YB3E, YB2E, YB1E, YB0E,
                ERAS, ERAS_, FNERAS_, REX, REY, WEX, WEY, ZID, IHENV, SETEK,
                SBE, SBESET, STBE, SBF, SBFSET, STBF, STRGAT,
                SETAB, SETAB_, SETCD, SETCD_, RESETA, RESETB, RESETC, RESETD, CLROPE, ROP_,
                TPARG_, TPGE, TPGF, NOTEST, NOTEST_, ILP, ILP_, RILP1, RILP1_,
                BR12B_, WL11_, WL16_, R1C, RB1, RSCG_, WSCG_, CXB1_, RSTK_, REDRST, SBYREL_, WHOMPA};
    endfunction

    // Expected outputs after the next edge, from the current inputs.
    function automatic plain_t model_plain();
        plain_t p;
        int addr, xi, ti, yi;
        logic eras, fixed, clamp;
        p = '0;
        addr = int'(sv);
        xi = addr % 8;
        ti = (addr / 8) % 8;
        yi = (addr / 64) % 4;
        for (int i = 0; i < 8; i++) begin
            p.xb[i] = (i == xi);
            p.xt[i] = (i == ti);
        end
        for (int i = 0; i < 4; i++) p.yb[i] = (i == yi);
        eras  = !S12 && !S11 && (addr / 8 != 0) && !SCAD && !GOJAM;
        fixed = !eras && !SCAD;
        clamp = MYCLMP || SBY;
        p.eras = eras;
        if (eras && tin(1, 9) && !clamp) begin
            p.xbe = p.xb;
            p.xte = p.xt;
            p.ybe = p.yb;
        end
        p.rex    = eras && tin(2, 4) && !clamp;
        p.rey    = p.rex;
        p.sbeset = eras && tv[4];
        p.sbe    = p.sbeset && !PHS4_;
        p.stbe   = p.sbe;
        p.setek  = eras && tv[6];
        p.ihenv  = eras && tin(7, 9);
        p.wex    = p.ihenv && !clamp;
        p.wey    = p.wex;
        p.zid    = p.wex;
        p.setab  = fixed && tin(1, 3) && !S11;
        p.setcd  = fixed && tin(1, 3) && S11;
        p.sbfset = fixed && tv[4];
        p.sbf    = p.sbfset && !PHS4_ && !MNHSBF;
        p.stbf   = p.sbf;
        p.strgat = p.stbe || p.stbf;
        if (fixed && tin(6, 12)) p.rst4 = clr;
        p.rop    = fixed && tv[8];
        p.clrope = fixed && tv[12];
        p.notest = CHINC || PSEUDO || INOUT || DV3764 || MP1 || SCAD;
        p.tpge   = tv[7] && !p.notest && eras;
        p.tpgf   = tv[7] && !p.notest && !eras;
        p.rilp1  = m_ilp;
        if (tv[12] || GOJAM) p.ilp = 1'b0;
        else if (p.strgat) p.ilp = 1'b1;
        else p.ilp = m_ilp;
        p.br12b  = BR12B;
        p.wl11   = WL11;
        p.wl16   = WL16;
        p.r1c    = !R1C_;
        p.rb1    = !RB1_;
        p.rscg   = !RSC_ && SCAD;
        p.wscg   = !WSC_ && SCAD;
        p.rstk   = !RT_ && TIMR;
        p.redrst = GOJAM || GOJ1;
        p.nsby   = !SBY;
        p.whompa = !WHOMP_ && !SBY;
        return p;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all(input logic [W-1:0] g, input logic [W-1:0] e);
        check("dec",   g[107:88], e[107:88]);
        check("dec_n", g[87:68],  e[87:68]);
        check("drv_e", g[67:48],  e[67:48]);
        check("eras",  g[47:38],  e[47:38]);
        check("sense", g[37:31],  e[37:31]);
        check("rope",  g[30:21],  e[30:21]);
        check("par",   g[20:12],  e[20:12]);
        check("buf",   g[11:0],   e[11:0]);
    endtask

    task automatic check_reset();
        compare_all(observed(), assemble('0));
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        sv = '0; tv = '0; clr = '0;
        S11 = 0; S12 = 0; PHS2_ = 1; PHS3_ = 1; PHS4_ = 1;
        GOJAM = 0; GOJ1 = 0; SBY = 0; SCAD = 0;
        RSC_ = 1; WSC_ = 1; RT_ = 1; R1C_ = 1; RB1_ = 1; WHOMP_ = 1; NISQL_ = 1;
        BR12B = 0; WL11 = 0; WL16 = 0;
        CHINC = 0; PSEUDO = 0; INOUT = 0; DV3764 = 0; MP1 = 0; MAMU = 0;
        TCSAJ3 = 0; TIMR = 0; CGA14 = 0; MYCLMP = 0; MNHSBF = 0;
    endtask

    task automatic set_t(input int k);
        tv = '0;
        tv[k] = 1'b1;
    endtask

    function automatic logic chance(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    task automatic randomize_inputs();
        sv = 9'($urandom_range(0, 511));
        if (chance(15)) sv = sv & 9'h007;
        set_t($urandom_range(1, 12));
        if (chance(10)) tv[$urandom_range(1, 12)] = 1'b1;
        clr = 4'($urandom_range(0, 15));
        S11 = chance(20); S12 = chance(25);
        PHS2_ = chance(50); PHS3_ = chance(50); PHS4_ = chance(50);
        GOJAM = chance(5); GOJ1 = chance(5); SBY = chance(5); SCAD = chance(10);
        RSC_ = chance(50); WSC_ = chance(50); RT_ = chance(50); R1C_ = chance(50);
        RB1_ = chance(50); WHOMP_ = chance(50); NISQL_ = chance(50);
        BR12B = chance(50); WL11 = chance(50); WL16 = chance(50);
        CHINC = chance(10); PSEUDO = chance(10); INOUT = chance(10); DV3764 = chance(10);
        MP1 = chance(10); MAMU = chance(50); TCSAJ3 = chance(50); TIMR = chance(50);
        CGA14 = chance(50); MYCLMP = chance(10); MNHSBF = chance(20);
    endtask

    // Queue the expectation, clock once, compare just after the edge.
    task automatic step();
        plain_t p;
        p = model_plain();
        m_ilp = p.ilp;
        exp_q.push_back(assemble(p));
        @(posedge CLOCK);
        #1;
        compare_all(observed(), exp_q.pop_front());
    endtask

    // ---------------- test sequence ----------------
    initial begin
        set_idle();
        m_ilp = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge CLOCK);
        #1;
        check_reset();
        @(negedge CLOCK);
        rst = 1'b0;

        // Address decode: S03..S01=101, S06..S04=011, S08..S07=10.
        sv = 9'o235;
        step();
        check("xb5", XB5, 1); check("xt3", XT3, 1); check("yb2", YB2, 1); check("xb5_n", XB5_, 0);

        // Erasable read then write at address 0o100.
        set_idle(); sv = 9'o100; set_t(2);
        step();
        check("rex", REX, 1); check("rey", REY, 1); check("xb0e", XB0E, 1);
        set_t(7);
        step();
        check("wex", WEX, 1); check("wey", WEY, 1); check("zid", ZID, 1); check("tpge_eras", TPGE, 1);

        // Fixed cycle strobe, ILP set, RILP1 follow, T12A clear.
        set_idle(); S12 = 1; sv = 9'o100; set_t(4); PHS4_ = 0;
        step();
        check("sbf", SBF, 1); check("stbf", STBF, 1); check("strgat", STRGAT, 1); check("ilp_set", ILP, 1);
        set_t(5); PHS4_ = 1;
        step();
        check("rilp1", RILP1, 1);
        set_t(12);
        step();
        check("clrope", CLROPE, 1); check("ilp_clr", ILP, 0);

        // Parity test suppressed by CHINC, then enabled on an erasable cycle.
        set_idle(); sv = 9'o100; set_t(7); CHINC = 1;
        step();
        check("tpge_notest", TPGE, 0); check("tpgf_notest", TPGF, 0); check("tparg_n", TPARG_, 1);
        CHINC = 0;
        step();
        check("tpge_on", TPGE, 1);

        // Monitor clamp kills read and the enabled drivers.
        set_idle(); sv = 9'o100; set_t(2); MYCLMP = 1;
        step();
        check("rex_clamp", REX, 0); check("xb0e_clamp", XB0E, 0);

        // GOJAM mid-cycle drops ERAS and the drives on the next edge.
        set_idle(); sv = 9'o100; set_t(3);
        step();
        GOJAM = 1; set_t(4);
        step();
        check("gojam_eras", ERAS, 0); check("gojam_rex", REX, 0); check("gojam_redrst", REDRST, 1);

        // Asynchronous reset between edges.
        set_idle(); S12 = 1; set_t(4); PHS4_ = 0;
        step();
        #2 rst = 1'b1;
        #1;
        check_reset();
        check("ilp_async_rst", ILP, 0);
        m_ilp = 1'b0;
        @(negedge CLOCK);
        rst = 1'b0;

        // Randomized cycles against the model.
        for (int n = 0; n < 1500; n++) begin
            randomize_inputs();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
